// File: rtl/regfile_sb_if.sv
// regfile_sb_if: bus bundle for the scoreboarded register file.
//   master : the pipeline side (decode/writeback). It drives the read addresses,
//            the writeback port and the issue port, and it samples the read data,
//            the hazard flags, pend_cnt and err_spurious.
//   slave  : the register file itself.
`timescale 1ns/1ps
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_addr;
    logic              busy1;
    logic              busy2;
    logic              stall;
    logic [ADDR_W:0]   pend_cnt;
    logic              err_spurious;

    modport master (
        output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data1, rd_data2, busy1, busy2, stall, pend_cnt, err_spurious
    );

    modport slave (
        input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data1, rd_data2, busy1, busy2, stall, pend_cnt, err_spurious
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: a register file with 2**ADDR_W entries and a pending-write scoreboard.
//   clk, reset : rising-edge clock; synchronous, active-high reset.
//   bus.rd_*   : two combinational read ports. Each one can optionally take the
//                same-cycle write data through a bypass.
//   bus.wr_*   : one synchronous writeback port. A writeback also retires the
//                pending bit of its register.
//   bus.iss_*  : issue port. It marks the destination register as pending.
//   bus.busy1, bus.busy2, bus.stall : hazard flags for the decode stage.
//   bus.pend_cnt     : registered count of pending registers.
//   bus.err_spurious : sticky flag, set by a writeback to a register that was not pending.
`timescale 1ns/1ps
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic        clk,
    input  logic        reset,
    regfile_sb_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);
    localparam bit BP    = (BYPASS != 0);

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic [DEPTH-1:0]  pending_r;
    logic [ADDR_W:0]   pend_cnt_r;
    logic              err_r;

    logic              wr_ok_s;
    logic              iss_ok_s;
    logic              same_addr_s;
    logic              cnt_inc_s;
    logic              cnt_dec_s;
    logic              spurious_s;
    logic [DEPTH-1:0]  one_hot_s;
    logic [DEPTH-1:0]  set_mask_s;
    logic [DEPTH-1:0]  clr_mask_s;
    logic [DATA_W-1:0] rd_data1_s;
    logic [DATA_W-1:0] rd_data2_s;
    logic              byp1_s;
    logic              byp2_s;

    // When the zero register is enabled, traffic to address 0 is filtered out
    // before it can reach the data array or the scoreboard.
    assign wr_ok_s     = bus.wr_en  & ~(ZR & (bus.wr_addr  == {ADDR_W{1'b0}}));
    assign iss_ok_s    = bus.iss_en & ~(ZR & (bus.iss_addr == {ADDR_W{1'b0}}));
    assign same_addr_s = iss_ok_s & wr_ok_s & (bus.iss_addr == bus.wr_addr);

    assign one_hot_s  = {{(DEPTH-1){1'b0}}, 1'b1};
    assign set_mask_s = iss_ok_s ? (one_hot_s << bus.iss_addr) : {DEPTH{1'b0}};
    assign clr_mask_s = wr_ok_s  ? (one_hot_s << bus.wr_addr)  : {DEPTH{1'b0}};

    // The count is adjusted by deltas. When issue and writeback hit the same
    // pending register in one cycle, the set wins, so that case must not decrement.
    assign cnt_inc_s  = iss_ok_s & ~pending_r[bus.iss_addr];
    assign cnt_dec_s  = wr_ok_s & pending_r[bus.wr_addr] & ~same_addr_s;
    assign spurious_s = wr_ok_s & ~pending_r[bus.wr_addr] & ~same_addr_s;

    // Data array: reset clears every entry, otherwise take the writeback.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_ok_s) begin
            regs_r[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Scoreboard state. The set mask is applied after the clear, which makes the set win.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r  <= {DEPTH{1'b0}};
            pend_cnt_r <= {(ADDR_W+1){1'b0}};
            err_r      <= 1'b0;
        end else begin
            pending_r  <= (pending_r & ~clr_mask_s) | set_mask_s;
            pend_cnt_r <= pend_cnt_r + {{ADDR_W{1'b0}}, cnt_inc_s}
                                     - {{ADDR_W{1'b0}}, cnt_dec_s};
            err_r      <= err_r | spurious_s;
        end
    end

    assign byp1_s = BP & bus.wr_en & (bus.wr_addr == bus.rd_addr1);
    assign byp2_s = BP & bus.wr_en & (bus.wr_addr == bus.rd_addr2);

    // Read port 1: the zero register takes priority, then the bypass, then the array.
    always_comb begin
        rd_data1_s = regs_r[bus.rd_addr1];
        if (ZR && (bus.rd_addr1 == {ADDR_W{1'b0}})) begin
            rd_data1_s = {DATA_W{1'b0}};
        end else if (byp1_s) begin
            rd_data1_s = bus.wr_data;
        end else begin
            rd_data1_s = regs_r[bus.rd_addr1];
        end
    end

    // Read port 2: same priority order as port 1.
    always_comb begin
        rd_data2_s = regs_r[bus.rd_addr2];
        if (ZR && (bus.rd_addr2 == {ADDR_W{1'b0}})) begin
            rd_data2_s = {DATA_W{1'b0}};
        end else if (byp2_s) begin
            rd_data2_s = bus.wr_data;
        end else begin
            rd_data2_s = regs_r[bus.rd_addr2];
        end
    end

    assign bus.rd_data1     = rd_data1_s;
    assign bus.rd_data2     = rd_data2_s;
    // A producer that is completing this cycle is consumed through the bypass,
    // so it does not stall. pending_r[0] is never set when ZERO_REG is enabled.
    assign bus.busy1        = pending_r[bus.rd_addr1] & ~byp1_s;
    assign bus.busy2        = pending_r[bus.rd_addr2] & ~byp2_s;
    assign bus.stall        = bus.busy1 | bus.busy2;
    assign bus.pend_cnt     = pend_cnt_r;
    assign bus.err_spurious = err_r;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed, self-checking bench for regfile_sb.
//   dut_a uses BYPASS=1 and dut_b uses BYPASS=0. Both share clk and reset.
//   Inputs change 1 ns after each rising edge, and checks run 1 ns after that.
`timescale 1ns/1ps
module tb_regfile_sb;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus_a ();
    regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        bus_a.wr_en = 1'b0; bus_a.wr_addr = 5'd0; bus_a.wr_data = 32'h0;
        bus_a.iss_en = 1'b0; bus_a.iss_addr = 5'd0;
        bus_a.rd_addr1 = 5'd0; bus_a.rd_addr2 = 5'd0;
    endtask

    task automatic idle_b();
        bus_b.wr_en = 1'b0; bus_b.wr_addr = 5'd0; bus_b.wr_data = 32'h0;
        bus_b.iss_en = 1'b0; bus_b.iss_addr = 5'd0;
        bus_b.rd_addr1 = 5'd0; bus_b.rd_addr2 = 5'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_a(); idle_b();
        // Writeback and issue traffic that the reset must override.
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd3; bus_a.wr_data = 32'hFFFF_FFFF;
        bus_a.iss_en = 1'b1; bus_a.iss_addr = 5'd3;
        tick(); tick();
        reset = 1'b0;
        idle_a();
        bus_a.rd_addr1 = 5'd3;
        #1;
        n_cmp++; if (bus_a.rd_data1 !== 32'h0) begin n_bad++; $display("FAIL reset_r3_data got=%h exp=%h", bus_a.rd_data1, 32'h0); end
        n_cmp++; if (bus_a.pend_cnt !== 6'd0) begin n_bad++; $display("FAIL reset_pend_cnt got=%0d exp=0", bus_a.pend_cnt); end
        n_cmp++; if (bus_a.err_spurious !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", bus_a.err_spurious); end
        n_cmp++; if (bus_a.busy1 !== 1'b0) begin n_bad++; $display("FAIL reset_busy1 got=%b exp=0", bus_a.busy1); end
        n_cmp++; if (bus_b.pend_cnt !== 6'd0) begin n_bad++; $display("FAIL reset_b_pend_cnt got=%0d exp=0", bus_b.pend_cnt); end
        // A write to r0 is discarded and must not show up through the bypass either.
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd0; bus_a.wr_data = 32'h0000_00A0;
        bus_a.rd_addr1 = 5'd0;
        #1;
        n_cmp++; if (bus_a.rd_data1 !== 32'h0) begin n_bad++; $display("FAIL zero_bypass got=%h exp=%h", bus_a.rd_data1, 32'h0); end
        tick();
        bus_a.wr_en = 1'b0;
        #1;
        n_cmp++; if (bus_a.rd_data1 !== 32'h0) begin n_bad++; $display("FAIL zero_read got=%h exp=%h", bus_a.rd_data1, 32'h0); end
        n_cmp++; if (bus_a.pend_cnt !== 6'd0) begin n_bad++; $display("FAIL zero_pend_cnt got=%0d exp=0", bus_a.pend_cnt); end
        n_cmp++; if (bus_a.err_spurious !== 1'b0) begin n_bad++; $display("FAIL zero_err got=%b exp=0", bus_a.err_spurious); end
    endtask

    task automatic test_bypass();
        bus_a.iss_en = 1'b1; bus_a.iss_addr = 5'd5;
        tick();
        bus_a.iss_en = 1'b0; bus_a.rd_addr1 = 5'd5;
        #1;
        n_cmp++; if (bus_a.busy1 !== 1'b1) begin n_bad++; $display("FAIL byp_busy1 got=%b exp=1", bus_a.busy1); end
        n_cmp++; if (bus_a.stall !== 1'b1) begin n_bad++; $display("FAIL byp_stall got=%b exp=1", bus_a.stall); end
        n_cmp++; if (bus_a.pend_cnt !== 6'd1) begin n_bad++; $display("FAIL byp_pend_cnt got=%0d exp=1", bus_a.pend_cnt); end
        tick();
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd5; bus_a.wr_data = 32'h0102_0408;
        #1;
        n_cmp++; if (bus_a.rd_data1 !== 32'h0102_0408) begin n_bad++; $display("FAIL byp_data got=%h exp=%h", bus_a.rd_data1, 32'h0102_0408); end
        n_cmp++; if (bus_a.busy1 !== 1'b0) begin n_bad++; $display("FAIL byp_busy_clear got=%b exp=0", bus_a.busy1); end
        n_cmp++; if (bus_a.stall !== 1'b0) begin n_bad++; $display("FAIL byp_stall_clear got=%b exp=0", bus_a.stall); end
        tick();
        bus_a.wr_en = 1'b0;
        #1;
        n_cmp++; if (bus_a.pend_cnt !== 6'd0) begin n_bad++; $display("FAIL byp_pend_after got=%0d exp=0", bus_a.pend_cnt); end
        n_cmp++; if (bus_a.rd_data1 !== 32'h0102_0408) begin n_bad++; $display("FAIL byp_stored got=%h exp=%h", bus_a.rd_data1, 32'h0102_0408); end
    endtask

    task automatic test_fill();
        logic [31:0] exp1;
        logic [31:0] exp2;
        for (int i = 1; i < 32; i++) begin
            bus_a.iss_en = 1'b1; bus_a.iss_addr = 5'(i);
            tick();
            bus_a.iss_en = 1'b0;
            #1;
            n_cmp++; if (bus_a.pend_cnt !== 6'd1) begin n_bad++; $display("FAIL fill_pend r%0d got=%0d exp=1", i, bus_a.pend_cnt); end
            bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'(i); bus_a.wr_data = 32'(i) * 32'h0102_0408;
            tick();
            bus_a.wr_en = 1'b0;
        end
        #1;
        n_cmp++; if (bus_a.pend_cnt !== 6'd0) begin n_bad++; $display("FAIL fill_pend_end got=%0d exp=0", bus_a.pend_cnt); end
        n_cmp++; if (bus_a.err_spurious !== 1'b0) begin n_bad++; $display("FAIL fill_err got=%b exp=0", bus_a.err_spurious); end
        for (int i = 1; i < 32; i++) begin
            bus_a.rd_addr1 = 5'(i);
            bus_a.rd_addr2 = 5'(32 - i);
            exp1 = 32'(i) * 32'h0102_0408;
            exp2 = 32'(32 - i) * 32'h0102_0408;
            #1;
            n_cmp++; if (bus_a.rd_data1 !== exp1) begin n_bad++; $display("FAIL fill_rd1 r%0d got=%h exp=%h", i, bus_a.rd_data1, exp1); end
            n_cmp++; if (bus_a.rd_data2 !== exp2) begin n_bad++; $display("FAIL fill_rd2 r%0d got=%h exp=%h", 32 - i, bus_a.rd_data2, exp2); end
        end
    endtask

    task automatic test_same_cycle();
        bus_a.iss_en = 1'b1; bus_a.iss_addr = 5'd7;
        tick();
        // r7 is pending: a new issue plus a writeback in the same cycle leaves it pending.
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd7; bus_a.wr_data = 32'h0000_0077;
        tick();
        bus_a.iss_en = 1'b0; bus_a.wr_en = 1'b0; bus_a.rd_addr1 = 5'd7;
        #1;
        n_cmp++; if (bus_a.pend_cnt !== 6'd1) begin n_bad++; $display("FAIL same_pend_cnt got=%0d exp=1", bus_a.pend_cnt); end
        n_cmp++; if (bus_a.busy1 !== 1'b1) begin n_bad++; $display("FAIL same_busy got=%b exp=1", bus_a.busy1); end
        n_cmp++; if (bus_a.rd_data1 !== 32'h0000_0077) begin n_bad++; $display("FAIL same_data got=%h exp=%h", bus_a.rd_data1, 32'h77); end
        bus_a.iss_en = 1'b1; bus_a.iss_addr = 5'd9;
        tick();
        // Issue to r3 and writeback to r9 in the same cycle: the count is unchanged.
        bus_a.iss_addr = 5'd3;
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd9; bus_a.wr_data = 32'h0000_0099;
        tick();
        bus_a.iss_en = 1'b0; bus_a.wr_en = 1'b0;
        bus_a.rd_addr1 = 5'd3; bus_a.rd_addr2 = 5'd9;
        #1;
        n_cmp++; if (bus_a.pend_cnt !== 6'd2) begin n_bad++; $display("FAIL diff_pend_cnt got=%0d exp=2", bus_a.pend_cnt); end
        n_cmp++; if (bus_a.busy1 !== 1'b1) begin n_bad++; $display("FAIL diff_busy_r3 got=%b exp=1", bus_a.busy1); end
        n_cmp++; if (bus_a.busy2 !== 1'b0) begin n_bad++; $display("FAIL diff_busy_r9 got=%b exp=0", bus_a.busy2); end
        n_cmp++; if (bus_a.rd_data2 !== 32'h0000_0099) begin n_bad++; $display("FAIL diff_data_r9 got=%h exp=%h", bus_a.rd_data2, 32'h99); end
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd7; bus_a.wr_data = 32'h0000_0777;
        tick();
        bus_a.wr_addr = 5'd3; bus_a.wr_data = 32'h0000_0333;
        tick();
        bus_a.wr_en = 1'b0;
        #1;
        n_cmp++; if (bus_a.pend_cnt !== 6'd0) begin n_bad++; $display("FAIL same_drain got=%0d exp=0", bus_a.pend_cnt); end
        n_cmp++; if (bus_a.err_spurious !== 1'b0) begin n_bad++; $display("FAIL same_err got=%b exp=0", bus_a.err_spurious); end
    endtask

    task automatic test_spurious();
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd12; bus_a.wr_data = 32'h0000_C0C0;
        #1;
        n_cmp++; if (bus_a.err_spurious !== 1'b0) begin n_bad++; $display("FAIL spur_before got=%b exp=0", bus_a.err_spurious); end
        tick();
        bus_a.wr_en = 1'b0; bus_a.rd_addr1 = 5'd12;
        #1;
        n_cmp++; if (bus_a.err_spurious !== 1'b1) begin n_bad++; $display("FAIL spur_set got=%b exp=1", bus_a.err_spurious); end
        n_cmp++; if (bus_a.rd_data1 !== 32'h0000_C0C0) begin n_bad++; $display("FAIL spur_data got=%h exp=%h", bus_a.rd_data1, 32'hC0C0); end
        tick(); tick(); tick();
        n_cmp++; if (bus_a.err_spurious !== 1'b1) begin n_bad++; $display("FAIL spur_sticky got=%b exp=1", bus_a.err_spurious); end
    endtask

    task automatic test_mid_reset();
        for (int i = 1; i <= 4; i++) begin
            bus_a.iss_en = 1'b1; bus_a.iss_addr = 5'(i);
            tick();
        end
        bus_a.iss_en = 1'b0; bus_a.rd_addr1 = 5'd1; bus_a.rd_addr2 = 5'd4;
        #1;
        n_cmp++; if (bus_a.pend_cnt !== 6'd4) begin n_bad++; $display("FAIL mid_pend_before got=%0d exp=4", bus_a.pend_cnt); end
        n_cmp++; if (bus_a.stall !== 1'b1) begin n_bad++; $display("FAIL mid_stall_before got=%b exp=1", bus_a.stall); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (bus_a.pend_cnt !== 6'd0) begin n_bad++; $display("FAIL mid_pend_after got=%0d exp=0", bus_a.pend_cnt); end
        n_cmp++; if (bus_a.busy1 !== 1'b0) begin n_bad++; $display("FAIL mid_busy1 got=%b exp=0", bus_a.busy1); end
        n_cmp++; if (bus_a.busy2 !== 1'b0) begin n_bad++; $display("FAIL mid_busy2 got=%b exp=0", bus_a.busy2); end
        n_cmp++; if (bus_a.stall !== 1'b0) begin n_bad++; $display("FAIL mid_stall got=%b exp=0", bus_a.stall); end
        n_cmp++; if (bus_a.err_spurious !== 1'b0) begin n_bad++; $display("FAIL mid_err got=%b exp=0", bus_a.err_spurious); end
        for (int i = 1; i < 32; i += 5) begin
            bus_a.rd_addr1 = 5'(i); bus_a.rd_addr2 = 5'(31 - i);
            #1;
            n_cmp++; if (bus_a.rd_data1 !== 32'h0) begin n_bad++; $display("FAIL mid_clear_rd1 r%0d got=%h exp=0", i, bus_a.rd_data1); end
            n_cmp++; if (bus_a.rd_data2 !== 32'h0) begin n_bad++; $display("FAIL mid_clear_rd2 r%0d got=%h exp=0", 31 - i, bus_a.rd_data2); end
        end
    endtask

    task automatic test_no_bypass();
        bus_b.iss_en = 1'b1; bus_b.iss_addr = 5'd5;
        tick();
        bus_b.iss_en = 1'b0;
        bus_b.wr_en = 1'b1; bus_b.wr_addr = 5'd5; bus_b.wr_data = 32'h0102_0408;
        bus_b.rd_addr1 = 5'd5;
        #1;
        n_cmp++; if (bus_b.rd_data1 !== 32'h0) begin n_bad++; $display("FAIL nobyp_old_data got=%h exp=0", bus_b.rd_data1); end
        n_cmp++; if (bus_b.busy1 !== 1'b1) begin n_bad++; $display("FAIL nobyp_busy got=%b exp=1", bus_b.busy1); end
        n_cmp++; if (bus_b.stall !== 1'b1) begin n_bad++; $display("FAIL nobyp_stall got=%b exp=1", bus_b.stall); end
        tick();
        bus_b.wr_en = 1'b0;
        #1;
        n_cmp++; if (bus_b.rd_data1 !== 32'h0102_0408) begin n_bad++; $display("FAIL nobyp_new_data got=%h exp=%h", bus_b.rd_data1, 32'h0102_0408); end
        n_cmp++; if (bus_b.busy1 !== 1'b0) begin n_bad++; $display("FAIL nobyp_busy_after got=%b exp=0", bus_b.busy1); end
        n_cmp++; if (bus_b.pend_cnt !== 6'd0) begin n_bad++; $display("FAIL nobyp_pend got=%0d exp=0", bus_b.pend_cnt); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_bypass();
        test_fill();
        test_same_cycle();
        test_spurious();
        test_mid_reset();
        test_no_bypass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
